ahb_slave_dmem: RTL and testbench
=================================

Name: ahb_slave_dmem

Overview:
- AHB-Lite responder (slave) serving the MIPS data memory; it is the far end of the memory-stage AHB master.
- Accepts pipelined address/data-phase transfers, stores data in a byte-lane-writable word array, and returns read data through HRDATA to the writeback mux.
- Inserts a configurable number of wait states and generates the two-cycle ERROR response for illegal accesses.

Parameters:
- DEPTH, 256, number of 32-bit words in the array.
- BASE_ADDR, 32'h0000_0000, byte address of word 0.
- WAIT_STATES, 0, HREADY-low cycles inserted before each OKAY data phase completes (0..15).

Ports:
- Hclk  in  1  bus clock; everything updates on the rising edge.
- Hrst_n  in  1  reset, synchronous, active-low.
- HSEL  in  1  slave select from the decoder.
- HADDR  in  32  byte address (address phase).
- HTRANS  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
- HWRITE  in  1  1 = write.
- HSIZE  in  3  0 = byte, 1 = half, 2 = word; other values are illegal.
- HWDATA  in  32  write data (data phase).
- HRDATA  out  32  read data (data phase).
- HREADY  out  1  transfer-complete / accept-next-address; this is the bus HREADY seen by the master.
- HRESP  out  1  0 = OKAY, 1 = ERROR.

Behaviour:
- Reset (Hrst_n=0 at an edge): state=IDLE, HREADY=1, HRESP=0, HRDATA=0, wait counter=0, pending transfer dropped (a write in flight is not committed). Array contents are not reset.
- Address-phase sampling: at a rising edge with HREADY=1, HSEL=1 and HTRANS[1]=1, latch HADDR, HWRITE and HSIZE. IDLE/BUSY or HSEL=0 gives a zero-wait OKAY and no access.
- Legality check, done at sampling:
  - offset = HADDR - BASE_ADDR must be < DEPTH*4;
  - HSIZE must be <= 2;
  - half accesses need HADDR[0]=0; word accesses need HADDR[1:0]=0.
- States:
  - IDLE (no pending data phase): HREADY=1, HRESP=0.
    - legal transfer sampled: to WAIT if WAIT_STATES>0, else to DATA;
    - illegal transfer: to ERR1.
  - WAIT: HREADY=0, HRESP=0, counter increments; after WAIT_STATES cycles go to DATA. The bus address is not sampled here.
  - DATA: HREADY=1, HRESP=0; the transfer completes at the end of this cycle.
    - Write: commit the HWDATA lanes selected by the latched HSIZE and HADDR[1:0] (little-endian) at this edge.
    - Read: HRDATA = full 32-bit word at the latched address, combinational from the array during this cycle.
    - The next address phase is sampled at the same edge; next state follows the IDLE rules.
  - ERR1: HREADY=0, HRESP=1, no array access, then ERR2.
  - ERR2: HREADY=1, HRESP=1. A new address phase may be sampled here (next state per IDLE rules); a master that cancels drives IDLE.
- HRDATA is 0 in every cycle except a read DATA cycle.
- Zero-wait throughput: one transfer per cycle; a back-to-back NONSEQ stream stays in DATA.
- Read-after-write to the same address in consecutive transfers returns the new data, because the write commits before the read's data phase.
- HREADY and HRESP are pure functions of the registered state; no combinational path from inputs.
- Wait counter width: 4 bits.
- Array index = offset[log2(DEPTH)+1:2].

Decomposition:
- Shared package ahb_pkg holds:
  - HTRANS codes (IDLE/BUSY/NONSEQ/SEQ);
  - HSIZE codes (BYTE/HALF/WORD);
  - HRESP codes (OKAY/ERROR);
  - slave state encoding (IDLE, WAIT, DATA, ERR1, ERR2).
- One sub-module, ahb_sram_core: DEPTH x 32 array with a 4-bit byte-enable synchronous write and a combinational read port.
- Lane-enable generation and the FSM stay in ahb_slave_dmem.

Test Plan:
- Reset, then hold Hrst_n=0 for 2 cycles -> HREADY=1, HRESP=0, HRDATA=0. Assert reset during a WAIT_STATES=3 write -> target word unchanged.
- WAIT_STATES=0: NONSEQ word write 0xDEADBEEF to 0x10, then NONSEQ read 0x10 back-to-back -> HREADY never low; HRDATA=0xDEADBEEF in the read data phase.
- Byte write 0xAA at 0x13 (HWDATA=0xAA000000) over word 0x11223344 -> read 0x10 returns 0xAA223344. Half write 0x5566 at 0x12 -> 0x55663344.
- WAIT_STATES=2 read of 0x20 -> HREADY low for exactly 2 cycles, then high with data. HADDR changes during the wait are ignored.
- Address BASE+DEPTH*4, and a word at 0x02 -> HREADY=0/HRESP=1, then HREADY=1/HRESP=1; array unchanged; a following legal transfer completes OKAY.
- HTRANS=BUSY, and HSEL=0 with HTRANS=NONSEQ -> HREADY=1, HRESP=0, no write, HRDATA=0.

Source files
------------

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite codes and the data-memory slave state encoding.
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'd0,
        HTRANS_BUSY   = 2'd1,
        HTRANS_NONSEQ = 2'd2,
        HTRANS_SEQ    = 2'd3
    } htrans_e;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_DATA = 3'd2,
        ST_ERR1 = 3'd3,
        ST_ERR2 = 3'd4
    } slv_state_e;

endpackage

// File: rtl/ahb_slave_dmem_if.sv
// AHB-Lite bus bundle between the memory-stage master and the data-memory slave.
interface ahb_slave_dmem_if;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HREADY;
    logic        HRESP;

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA,
        input  HRDATA, HREADY, HRESP
    );

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA,
        output HRDATA, HREADY, HRESP
    );
endinterface

// File: rtl/ahb_sram_core.sv
// DEPTH x 32 word array: byte-enable synchronous write, combinational read.
module ahb_sram_core #(
    parameter int DEPTH = 256,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic [3:0]    we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [3:0][7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        for (int l = 0; l < 4; l++) begin
            if (we[l]) mem[addr][l] <= wdata[8*l +: 8];
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/ahb_slave_dmem.sv
// AHB-Lite data-memory slave: address/data pipelining, wait states, two-cycle ERROR.
module ahb_slave_dmem
    import ahb_pkg::*;
#(
    parameter int          DEPTH       = 256,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_STATES = 0
) (
    input  logic              Hclk,
    input  logic              Hrst_n,
    ahb_slave_dmem_if.slave   bus
);

    localparam int AW = $clog2(DEPTH);

    slv_state_e  state_q, state_d, accept_st;
    logic        hready_q, hready_d;
    logic        hresp_q, hresp_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        write_q, write_d;
    logic [2:0]  size_q, size_d;
    logic [AW+1:0] off_q, off_d;

    logic [31:0] offset;
    logic        sample, legal;
    logic [3:0]  be;
    logic [31:0] rdata;

    always_comb begin
        offset = bus.HADDR - BASE_ADDR;
        sample = hready_q && bus.HSEL &&
                 (bus.HTRANS == HTRANS_NONSEQ || bus.HTRANS == HTRANS_SEQ);
        // Unsigned offset: addresses below BASE_ADDR wrap high and fail the range test.
        legal  = (offset < 32'(DEPTH*4)) && (bus.HSIZE <= HSIZE_WORD) &&
                 !(bus.HSIZE == HSIZE_HALF && bus.HADDR[0]) &&
                 !(bus.HSIZE == HSIZE_WORD && bus.HADDR[1:0] != 2'b00);
        if (!sample)              accept_st = ST_IDLE;
        else if (!legal)          accept_st = ST_ERR1;
        else if (WAIT_STATES > 0) accept_st = ST_WAIT;
        else                      accept_st = ST_DATA;

        state_d = state_q;
        cnt_d   = cnt_q;
        write_d = write_q;
        size_d  = size_q;
        off_d   = off_q;
        case (state_q)
            ST_WAIT: begin
                if (cnt_q == 4'(WAIT_STATES-1)) begin
                    state_d = ST_DATA;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_ERR1: state_d = ST_ERR2;
            default: begin
                state_d = accept_st;
                if (sample) begin
                    write_d = bus.HWRITE;
                    size_d  = bus.HSIZE;
                    off_d   = offset[AW+1:0];
                end
            end
        endcase

        // Outputs are registered from the next state so they never see the inputs combinationally.
        hready_d = !(state_d == ST_WAIT || state_d == ST_ERR1);
        hresp_d  = (state_d == ST_ERR1 || state_d == ST_ERR2) ? HRESP_ERROR : HRESP_OKAY;
    end

    always_ff @(posedge Hclk) begin
        if (!Hrst_n) begin
            state_q  <= ST_IDLE;
            hready_q <= 1'b1;
            hresp_q  <= HRESP_OKAY;
            cnt_q    <= 4'd0;
            write_q  <= 1'b0;
            size_q   <= HSIZE_BYTE;
            off_q    <= '0;
        end else begin
            state_q  <= state_d;
            hready_q <= hready_d;
            hresp_q  <= hresp_d;
            cnt_q    <= cnt_d;
            write_q  <= write_d;
            size_q   <= size_d;
            off_q    <= off_d;
        end
    end

    // Little-endian lane select; HWDATA already sits on its natural byte lanes.
    always_comb begin
        be = 4'b0000;
        if (state_q == ST_DATA && write_q) begin
            case (size_q)
                HSIZE_BYTE: be = 4'b0001 << off_q[1:0];
                HSIZE_HALF: be = off_q[1] ? 4'b1100 : 4'b0011;
                default:    be = 4'b1111;
            endcase
        end
    end

    ahb_sram_core #(.DEPTH(DEPTH)) u_core (
        .clk   (Hclk),
        .we    (be),
        .addr  (off_q[AW+1:2]),
        .wdata (bus.HWDATA),
        .rdata (rdata)
    );

    assign bus.HRDATA = (state_q == ST_DATA && !write_q) ? rdata : 32'h0;
    assign bus.HREADY = hready_q;
    assign bus.HRESP  = hresp_q;

endmodule

// File: tb/tb_ahb_slave_dmem.sv
// Directed bench: three slaves (0, 2, 3 wait states) sharing one master driver, selected by sel.
module tb_ahb_slave_dmem;
    import ahb_pkg::*;

    logic        clk = 1'b0;
    logic        rst0_n, rst2_n, rst3_n;
    logic        hsel, hwrite;
    logic [31:0] haddr, hwdata;
    logic [1:0]  htrans;
    logic [2:0]  hsize;
    int          sel;
    int          passed = 0;
    int          total  = 0;
    int          lows;

    logic        o_rdy, o_resp;
    logic [31:0] o_rdata;

    ahb_slave_dmem_if if0 ();
    ahb_slave_dmem_if if2 ();
    ahb_slave_dmem_if if3 ();

    assign if0.HSEL = hsel && (sel == 0);
    assign if2.HSEL = hsel && (sel == 2);
    assign if3.HSEL = hsel && (sel == 3);
    assign if0.HADDR = haddr;  assign if2.HADDR = haddr;  assign if3.HADDR = haddr;
    assign if0.HTRANS = htrans; assign if2.HTRANS = htrans; assign if3.HTRANS = htrans;
    assign if0.HWRITE = hwrite; assign if2.HWRITE = hwrite; assign if3.HWRITE = hwrite;
    assign if0.HSIZE = hsize;  assign if2.HSIZE = hsize;  assign if3.HSIZE = hsize;
    assign if0.HWDATA = hwdata; assign if2.HWDATA = hwdata; assign if3.HWDATA = hwdata;

    ahb_slave_dmem #(.DEPTH(256), .BASE_ADDR(32'h0), .WAIT_STATES(0)) u_dut0 (
        .Hclk(clk), .Hrst_n(rst0_n), .bus(if0.slave));
    ahb_slave_dmem #(.DEPTH(256), .BASE_ADDR(32'h0), .WAIT_STATES(2)) u_dut2 (
        .Hclk(clk), .Hrst_n(rst2_n), .bus(if2.slave));
    ahb_slave_dmem #(.DEPTH(256), .BASE_ADDR(32'h0), .WAIT_STATES(3)) u_dut3 (
        .Hclk(clk), .Hrst_n(rst3_n), .bus(if3.slave));

    always #5 clk = ~clk;

    always_comb begin
        o_rdy   = if0.HREADY;
        o_resp  = if0.HRESP;
        o_rdata = if0.HRDATA;
        if (sel == 2) begin
            o_rdy = if2.HREADY; o_resp = if2.HRESP; o_rdata = if2.HRDATA;
        end else if (sel == 3) begin
            o_rdy = if3.HREADY; o_resp = if3.HRESP; o_rdata = if3.HRDATA;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic idle_bus();
        hsel   = 1'b0;
        htrans = HTRANS_IDLE;
    endtask

    task automatic addr_ph(input logic [31:0] a, input logic w, input logic [2:0] sz);
        hsel   = 1'b1;
        htrans = HTRANS_NONSEQ;
        haddr  = a;
        hwrite = w;
        hsize  = sz;
    endtask

    // Returns at the negedge of the first HREADY-high cycle; bounded so a stuck slave cannot hang.
    task automatic wait_rdy(output int n);
        n = 0;
        mid();
        while (o_rdy !== 1'b1 && n < 20) begin
            n++;
            tick();
            mid();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        sel = 0; rst0_n = 1'b0; rst2_n = 1'b0; rst3_n = 1'b0;
        haddr = 32'h0; hwrite = 1'b0; hsize = HSIZE_WORD; hwdata = 32'h0;
        idle_bus();
        tick(); tick();
        mid();
        chk("rst_hready", 32'(o_rdy), 32'h1);
        chk("rst_hresp",  32'(o_resp), 32'h0);
        chk("rst_hrdata", o_rdata, 32'h0);
        rst0_n = 1'b1; rst2_n = 1'b1; rst3_n = 1'b1;
        tick();

        // Zero-wait write then read back-to-back
        addr_ph(32'h10, 1'b1, HSIZE_WORD); tick();
        hwdata = 32'hDEADBEEF; addr_ph(32'h10, 1'b0, HSIZE_WORD);
        mid(); chk("ws0_wr_ready", 32'(o_rdy), 32'h1); tick();
        idle_bus();
        mid(); chk("ws0_rd_ready", 32'(o_rdy), 32'h1);
        chk("ws0_rd_data", o_rdata, 32'hDEADBEEF); tick();
        mid(); chk("idle_rdata_zero", o_rdata, 32'h0);

        // Byte and half-word lane writes with read-after-write
        addr_ph(32'h10, 1'b1, HSIZE_WORD); tick();
        hwdata = 32'h11223344; addr_ph(32'h13, 1'b1, HSIZE_BYTE); tick();
        hwdata = 32'hAA000000; addr_ph(32'h10, 1'b0, HSIZE_WORD); tick();
        addr_ph(32'h12, 1'b1, HSIZE_HALF);
        mid(); chk("byte_lane3", o_rdata, 32'hAA223344); tick();
        hwdata = 32'h55660000; addr_ph(32'h10, 1'b0, HSIZE_WORD); tick();
        idle_bus();
        mid(); chk("half_upper", o_rdata, 32'h55663344); tick();

        // Two wait states: write 0x20, then read it while HADDR wanders
        sel = 2;
        addr_ph(32'h20, 1'b1, HSIZE_WORD); tick();
        hwdata = 32'hCAFEF00D; idle_bus();
        wait_rdy(lows);
        chk("ws2_wr_lows", lows, 2);
        addr_ph(32'h20, 1'b0, HSIZE_WORD); tick();
        addr_ph(32'h401, 1'b1, HSIZE_WORD);
        wait_rdy(lows);
        chk("ws2_rd_lows", lows, 2);
        chk("ws2_rd_data", o_rdata, 32'hCAFEF00D);
        chk("ws2_rd_resp", 32'(o_resp), 32'h0);
        idle_bus(); tick();
        mid(); chk("ws2_after_resp", 32'(o_resp), 32'h0);
        tick();

        // Three wait states: reset mid-write must drop the pending commit
        sel = 3;
        addr_ph(32'h30, 1'b1, HSIZE_WORD); tick();
        hwdata = 32'h12345678; idle_bus();
        wait_rdy(lows);
        chk("ws3_wr_lows", lows, 3);
        addr_ph(32'h30, 1'b1, HSIZE_WORD); tick();
        hwdata = 32'hFFFFFFFF; idle_bus(); tick();
        rst3_n = 1'b0; tick();
        rst3_n = 1'b1;
        mid(); chk("ws3_rst_hready", 32'(o_rdy), 32'h1);
        addr_ph(32'h30, 1'b0, HSIZE_WORD); tick();
        idle_bus();
        wait_rdy(lows);
        chk("ws3_rst_nocommit", o_rdata, 32'h12345678);
        tick();

        // ERROR responses: out of range, then misaligned word issued from ERR2
        sel = 0;
        addr_ph(32'h0, 1'b1, HSIZE_WORD); tick();
        hwdata = 32'h01020304; addr_ph(32'h400, 1'b1, HSIZE_WORD); tick();
        hwdata = 32'hFFFFFFFF; idle_bus();
        mid(); chk("err1_hready", 32'(o_rdy), 32'h0);
        chk("err1_hresp", 32'(o_resp), 32'h1); tick();
        addr_ph(32'h02, 1'b1, HSIZE_WORD);
        mid(); chk("err2_hready", 32'(o_rdy), 32'h1);
        chk("err2_hresp", 32'(o_resp), 32'h1); tick();
        idle_bus();
        mid(); chk("mis_err1", {30'h0, o_rdy, o_resp}, 32'h1); tick();
        addr_ph(32'h0, 1'b0, HSIZE_WORD);
        mid(); chk("mis_err2", {30'h0, o_rdy, o_resp}, 32'h3); tick();
        idle_bus();
        mid(); chk("post_err_okay", {30'h0, o_rdy, o_resp}, 32'h2);
        chk("post_err_data", o_rdata, 32'h01020304); tick();

        // BUSY and deselected NONSEQ produce no access
        hsel = 1'b1; htrans = HTRANS_BUSY; haddr = 32'h0; hwrite = 1'b1; hsize = HSIZE_WORD;
        tick();
        hwdata = 32'hFFFFFFFF; idle_bus();
        mid(); chk("busy_okay", {30'h0, o_rdy, o_resp}, 32'h2);
        chk("busy_rdata", o_rdata, 32'h0); tick();
        addr_ph(32'h0, 1'b1, HSIZE_WORD); hsel = 1'b0; tick();
        hwdata = 32'hFFFFFFFF; idle_bus();
        mid(); chk("nosel_okay", {30'h0, o_rdy, o_resp}, 32'h2);
        chk("nosel_rdata", o_rdata, 32'h0); tick();
        addr_ph(32'h0, 1'b0, HSIZE_WORD); tick();
        idle_bus();
        mid(); chk("no_write_seen", o_rdata, 32'h01020304); tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
